// File: rtl/load_stuff.sv
// Stock-table loader: parses ENTRIES lines of WIDTH ASCII binary digits (LF-terminated,
// optional CR before LF) into a shadow table and publishes it atomically on success.
module load_stuff #(
  parameter int ENTRIES = 8,
  parameter int WIDTH   = 11
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [7:0]                 in_byte,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [ENTRIES*WIDTH-1:0]   data_flat,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [3:0]                 entry_cnt,
  output logic [2:0]                 state_dbg
);
  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on state, never on in_valid.
  localparam int DW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_DIGIT, S_EOL, S_DONE, S_ERR} state_t;

  state_t                   state_q, state_d;
  logic [WIDTH-1:0]         shift_q, shift_d;
  logic [DW-1:0]            dcnt_q, dcnt_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [WIDTH-1:0]         shadow_q [ENTRIES];
  logic [WIDTH-1:0]         shadow_d [ENTRIES];
  logic [ENTRIES*WIDTH-1:0] data_q, data_d;
  logic                     err_q, err_d;
  logic                     xfer;
  logic                     is_digit;

  assign in_ready  = (state_q == S_DIGIT) || (state_q == S_EOL);
  assign busy      = in_ready || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign error     = err_q;
  assign entry_cnt = cnt_q;
  assign data_flat = data_q;
  assign state_dbg = state_q;

  assign xfer     = in_valid && in_ready;
  assign is_digit = (in_byte == 8'h30) || (in_byte == 8'h31);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    dcnt_d   = dcnt_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d = S_DIGIT;
          err_d   = 1'b0;
          cnt_d   = '0;
          dcnt_d  = '0;
          shift_d = '0;
        end
      end
      S_DIGIT: begin
        if (xfer) begin
          if (is_digit) begin
            shift_d = {shift_q[WIDTH-2:0], in_byte[0]};
            dcnt_d  = dcnt_q + DW'(1);
            if (dcnt_q == DW'(WIDTH - 1)) state_d = S_EOL;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_EOL: begin
        if (xfer) begin
          if (in_byte == 8'h0A) begin
            for (int i = 0; i < ENTRIES; i++) begin
              if (cnt_q == 4'(i)) shadow_d[i] = shift_q;
            end
            dcnt_d = '0;
            if (cnt_q != 4'(ENTRIES)) cnt_d = cnt_q + 4'd1;
            // Publish includes the entry being written on this same edge.
            if (cnt_q >= 4'(ENTRIES - 1)) begin
              state_d = S_DONE;
              for (int i = 0; i < ENTRIES; i++) data_d[WIDTH*i +: WIDTH] = shadow_d[i];
            end else begin
              state_d = S_DIGIT;
            end
          end else if (in_byte != 8'h0D) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      dcnt_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) shadow_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      dcnt_q   <= dcnt_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
    end
  end
endmodule

// File: tb/tb_load_stuff.sv
// Bench for load_stuff: builds ASCII stock streams, predicts the outcome with a
// line-oriented parser model and checks outputs scenario by scenario.
module tb_load_stuff;
  localparam int ENTRIES = 8;
  localparam int WIDTH   = 11;
  localparam int FLAT    = ENTRIES * WIDTH;
  localparam int FULL_CYCLES = ENTRIES * (WIDTH + 1) + 2;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            start;
  logic [7:0]      in_byte;
  logic            in_valid;
  logic            in_ready;
  logic [FLAT-1:0] data_flat;
  logic            busy;
  logic            done;
  logic            error;
  logic [3:0]      entry_cnt;
  logic [2:0]      state_dbg;

  load_stuff #(.ENTRIES(ENTRIES), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .in_byte(in_byte),
    .in_valid(in_valid), .in_ready(in_ready), .data_flat(data_flat), .busy(busy),
    .done(done), .error(error), .entry_cnt(entry_cnt), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int done_total = 0;
  always @(negedge clock) if (done === 1'b1) done_total <= done_total + 1;

  logic [7:0]       stream_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] tbl [ENTRIES];
  logic [FLAT-1:0]  exp_flat;
  bit m_ok;
  int m_good, m_err_idx, dn, acc, d0;

  function automatic void build_stream(input int crlf, input int short_line, input int long_line,
                                       input int bad_line, input int bad_pos);
    logic [7:0] ch;
    int nd;
    stream_q.delete();
    for (int i = 0; i < ENTRIES; i++) begin
      nd = (i == short_line) ? WIDTH - 1 : WIDTH;
      for (int k = 0; k < nd; k++) begin
        ch = tbl[i][WIDTH-1-k] ? 8'h31 : 8'h30;
        if (i == bad_line && k == bad_pos) ch = 8'h78;
        stream_q.push_back(ch);
      end
      if (i == long_line) stream_q.push_back(8'h31);
      if (crlf == 1 || (crlf == 2 && $urandom_range(1) == 1)) stream_q.push_back(8'h0D);
      stream_q.push_back(8'h0A);
    end
  endfunction

  // Splits the stream into LF-terminated lines; a line is good when it has exactly
  // WIDTH binary digits followed only by CRs. Stops at the first bad byte.
  function automatic void model_parse(output bit ok, output int good, output int err_idx);
    logic [7:0] line[$];
    int start_i, pos, v;
    exp_q.delete();
    ok = 0; good = 0; err_idx = -1; start_i = 0;
    for (int i = 0; i < stream_q.size(); i++) begin
      if (stream_q[i] != 8'h0A) begin
        line.push_back(stream_q[i]);
        continue;
      end
      pos = -1;
      for (int k = 0; k < line.size() && pos < 0; k++) begin
        if (k < WIDTH && line[k] != 8'h30 && line[k] != 8'h31) pos = k;
        else if (k >= WIDTH && line[k] != 8'h0D) pos = k;
      end
      if (pos < 0 && line.size() < WIDTH) pos = line.size();
      if (pos >= 0) begin
        err_idx = start_i + pos;
        return;
      end
      v = 0;
      for (int k = 0; k < WIDTH; k++) v = v * 2 + ((line[k] == 8'h31) ? 1 : 0);
      exp_q.push_back(WIDTH'(v));
      good++;
      line.delete();
      start_i = i + 1;
      if (good == ENTRIES) begin
        ok = 1;
        return;
      end
    end
  endfunction

  function automatic logic [FLAT-1:0] pack_exp();
    logic [FLAT-1:0] f;
    f = '0;
    for (int i = 0; i < exp_q.size() && i < ENTRIES; i++) f[WIDTH*i +: WIDTH] = exp_q[i];
    return f;
  endfunction

  // Pulses start, then feeds stream_q. stall_mode: 0 continuous, 1 toggle, 2 random.
  task automatic run_load(input int stall_mode, input int start_at, input int stop_at_cnt,
                          output int done_n, output int accepted);
    int n, idx;
    bit rdy, pulsed;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 1; idx = 0; accepted = 0; done_n = -1; pulsed = 0;
    for (int c = 0; c < 3000; c++) begin
      if (stop_at_cnt > 0 && entry_cnt == 4'(stop_at_cnt)) break;
      if (idx < stream_q.size()) begin
        in_byte = stream_q[idx];
        case (stall_mode)
          0:       in_valid = 1'b1;
          1:       in_valid = (c % 2 == 0);
          default: in_valid = ($urandom_range(3) != 0);
        endcase
      end else begin
        in_valid = 1'b0;
      end
      if (!pulsed && start_at >= 0 && idx >= start_at) begin
        start = 1'b1;
        pulsed = 1;
      end
      rdy = in_ready;
      @(posedge clock);
      n++;
      if (in_valid && rdy) begin
        idx++;
        accepted++;
      end
      #1;
      start = 1'b0;
      if (done) begin
        done_n = n;
        break;
      end
      if (!busy) break;
    end
    in_valid = 1'b0;
    if (done_n >= 0) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    #12;
    tests++;
    if ({in_ready, busy, done, error} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b expected 0000", {in_ready, busy, done, error});
    end
    tests++;
    if (entry_cnt !== 4'd0) begin fails++; $display("FAIL reset_cnt: got %0d expected 0", entry_cnt); end
    tests++;
    if (data_flat !== '0) begin fails++; $display("FAIL reset_data: got %h expected 0", data_flat); end
    exp_flat = '0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_clean_load();
    for (int i = 0; i < ENTRIES; i++) tbl[i] = WIDTH'(i + 1);
    build_stream(0, -1, -1, -1, -1);
    model_parse(m_ok, m_good, m_err_idx);
    d0 = done_total;
    run_load(0, -1, 0, dn, acc);
    tests++;
    if (dn + 1 != FULL_CYCLES) begin fails++; $display("FAIL clean_latency: got cycle %0d expected %0d", dn + 1, FULL_CYCLES); end
    tests++;
    if (data_flat !== pack_exp()) begin fails++; $display("FAIL clean_data: got %h expected %h", data_flat, pack_exp()); end
    tests++;
    if (error !== 1'b0) begin fails++; $display("FAIL clean_error: got %b expected 0", error); end
    tests++;
    if (entry_cnt !== 4'(ENTRIES)) begin fails++; $display("FAIL clean_cnt: got %0d expected %0d", entry_cnt, ENTRIES); end
    tests++;
    if (done_total - d0 != 1) begin fails++; $display("FAIL clean_done_pulses: got %0d expected 1", done_total - d0); end
    exp_flat = pack_exp();
  endtask

  task automatic test_crlf_stalls();
    for (int i = 0; i < ENTRIES; i++) tbl[i] = WIDTH'(i + 1);
    build_stream(1, -1, -1, -1, -1);
    model_parse(m_ok, m_good, m_err_idx);
    d0 = done_total;
    run_load(1, -1, 0, dn, acc);
    tests++;
    if (data_flat !== pack_exp()) begin fails++; $display("FAIL crlf_data: got %h expected %h", data_flat, pack_exp()); end
    tests++;
    if (done_total - d0 != 1) begin fails++; $display("FAIL crlf_done_pulses: got %0d expected 1", done_total - d0); end
    tests++;
    if (acc != stream_q.size()) begin fails++; $display("FAIL crlf_bytes: got %0d expected %0d", acc, stream_q.size()); end
    exp_flat = pack_exp();
  endtask

  task automatic test_short_line();
    for (int i = 0; i < ENTRIES; i++) tbl[i] = '1;
    build_stream(0, -1, -1, -1, -1);
    model_parse(m_ok, m_good, m_err_idx);
    run_load(0, -1, 0, dn, acc);
    exp_flat = pack_exp();
    tests++;
    if (data_flat !== exp_flat) begin fails++; $display("FAIL preload_data: got %h expected %h", data_flat, exp_flat); end
    for (int i = 0; i < ENTRIES; i++) tbl[i] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    build_stream(0, 2, -1, -1, -1);
    model_parse(m_ok, m_good, m_err_idx);
    run_load(0, -1, 0, dn, acc);
    tests++;
    if ({error, busy, in_ready} !== 3'b100) begin
      fails++; $display("FAIL short_flags: got err/busy/rdy %b expected 100", {error, busy, in_ready});
    end
    tests++;
    if (entry_cnt !== 4'(m_good)) begin fails++; $display("FAIL short_cnt: got %0d expected %0d", entry_cnt, m_good); end
    tests++;
    if (acc != m_err_idx + 1) begin fails++; $display("FAIL short_bytes: got %0d expected %0d", acc, m_err_idx + 1); end
    tests++;
    if (data_flat !== exp_flat) begin fails++; $display("FAIL short_data: got %h expected %h", data_flat, exp_flat); end
  endtask

  task automatic test_bad_char();
    for (int i = 0; i < ENTRIES; i++) tbl[i] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    build_stream(0, -1, -1, 0, 4);
    model_parse(m_ok, m_good, m_err_idx);
    run_load(0, -1, 0, dn, acc);
    tests++;
    if (error !== 1'b1) begin fails++; $display("FAIL bad_error: got %b expected 1", error); end
    tests++;
    if (acc != m_err_idx + 1) begin fails++; $display("FAIL bad_edge: got %0d bytes expected %0d", acc, m_err_idx + 1); end
    tests++;
    if (entry_cnt !== 4'(m_good)) begin fails++; $display("FAIL bad_cnt: got %0d expected %0d", entry_cnt, m_good); end
    build_stream(0, -1, -1, -1, -1);
    model_parse(m_ok, m_good, m_err_idx);
    d0 = done_total;
    run_load(0, -1, 0, dn, acc);
    tests++;
    if (error !== 1'b0) begin fails++; $display("FAIL recover_error: got %b expected 0", error); end
    tests++;
    if (done_total - d0 != 1) begin fails++; $display("FAIL recover_done: got %0d expected 1", done_total - d0); end
    tests++;
    if (data_flat !== pack_exp()) begin fails++; $display("FAIL recover_data: got %h expected %h", data_flat, pack_exp()); end
    exp_flat = pack_exp();
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < ENTRIES; i++) tbl[i] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    build_stream(0, -1, -1, -1, -1);
    run_load(0, -1, 4, dn, acc);
    tests++;
    if (entry_cnt !== 4'd4) begin fails++; $display("FAIL midload_reach: got %0d expected 4", entry_cnt); end
    #2;
    reset_n = 1'b0;
    #1;
    exp_flat = '0;
    tests++;
    if ({in_ready, busy, done, error} !== 4'b0000) begin
      fails++; $display("FAIL midreset_flags: got %b expected 0000", {in_ready, busy, done, error});
    end
    tests++;
    if (entry_cnt !== 4'd0) begin fails++; $display("FAIL midreset_cnt: got %0d expected 0", entry_cnt); end
    tests++;
    if (data_flat !== exp_flat) begin fails++; $display("FAIL midreset_data: got %h expected 0", data_flat); end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < ENTRIES; i++) tbl[i] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    build_stream(0, -1, -1, -1, -1);
    model_parse(m_ok, m_good, m_err_idx);
    d0 = done_total;
    run_load(0, -1, 0, dn, acc);
    tests++;
    if (data_flat !== pack_exp()) begin fails++; $display("FAIL postreset_data: got %h expected %h", data_flat, pack_exp()); end
    tests++;
    if (done_total - d0 != 1) begin fails++; $display("FAIL postreset_done: got %0d expected 1", done_total - d0); end
    exp_flat = pack_exp();
  endtask

  task automatic test_ignored_start();
    for (int i = 0; i < ENTRIES; i++) tbl[i] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    build_stream(0, -1, -1, -1, -1);
    model_parse(m_ok, m_good, m_err_idx);
    d0 = done_total;
    run_load(0, WIDTH + 1 + 3, 0, dn, acc);
    tests++;
    if (dn + 1 != FULL_CYCLES) begin fails++; $display("FAIL ignstart_latency: got cycle %0d expected %0d", dn + 1, FULL_CYCLES); end
    tests++;
    if (entry_cnt !== 4'(ENTRIES)) begin fails++; $display("FAIL ignstart_cnt: got %0d expected %0d", entry_cnt, ENTRIES); end
    tests++;
    if (data_flat !== pack_exp()) begin fails++; $display("FAIL ignstart_data: got %h expected %h", data_flat, pack_exp()); end
    tests++;
    if (done_total - d0 != 1) begin fails++; $display("FAIL ignstart_done: got %0d expected 1", done_total - d0); end
    exp_flat = pack_exp();
  endtask

  task automatic test_random();
    int kind, ln;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      kind = $urandom_range(0, 3);
      ln = $urandom_range(0, ENTRIES - 1);
      build_stream(2, (kind == 1) ? ln : -1, (kind == 2) ? ln : -1,
                   (kind == 3) ? ln : -1, $urandom_range(0, WIDTH - 1));
      model_parse(m_ok, m_good, m_err_idx);
      d0 = done_total;
      run_load(2, -1, 0, dn, acc);
      if (m_ok) begin
        exp_flat = pack_exp();
        tests++;
        if (done_total - d0 != 1 || error !== 1'b0) begin
          fails++; $display("FAIL rand_ok_%0d: got done %0d err %b expected 1 0", it, done_total - d0, error);
        end
      end else begin
        tests++;
        if (error !== 1'b1 || entry_cnt !== 4'(m_good) || acc != m_err_idx + 1) begin
          fails++; $display("FAIL rand_err_%0d: got err %b cnt %0d bytes %0d expected 1 %0d %0d",
                            it, error, entry_cnt, acc, m_good, m_err_idx + 1);
        end
      end
      tests++;
      if (data_flat !== exp_flat) begin fails++; $display("FAIL rand_data_%0d: got %h expected %h", it, data_flat, exp_flat); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_load();
    test_crlf_stalls();
    test_short_line();
    test_bad_char();
    test_reset_midload();
    test_ignored_start();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
